// File: rtl/upload_reader.sv
// upload_reader: serves data_io upload bytes from SDRAM words fetched over a toggle req/ack port,
// with a current-word buffer and a one-word prefetch buffer.
module upload_reader #(
    parameter logic [24:0] BASE_ADDR     = 25'h0,
    parameter int          SIZE_BYTES    = 8192,
    parameter int          RESYNC_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_upload,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_ack,
    input  logic [15:0] sdr_dout,
    output logic        busy
);
    typedef enum logic [2:0] {RESYNC, IDLE, PREFETCH, WAIT_CUR, WAIT_NXT} state_t;
    typedef struct packed {
        logic        v;
        logic [23:0] t;
        logic [15:0] w;
    } buf_t;

    localparam int             CW    = $clog2(RESYNC_CYCLES + 1);
    localparam logic [25:0]    SIZE  = 26'(SIZE_BYTES);
    localparam logic [CW-1:0]  CLAST = CW'(RESYNC_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic [23:0]   tag_q, tag_d;
    buf_t          cur_q, cur_d, nxt_q, nxt_d;

    logic [23:0] widx, widx_p1;
    logic        in_range, nxt_in, ack_m, cur_hit, nxt_hit, need_pf, go;

    assign widx     = ioctl_addr[24:1];
    assign widx_p1  = widx + 24'd1;
    assign in_range = {1'b0, ioctl_addr} < SIZE;
    assign nxt_in   = ({1'b0, widx, 1'b0} + 26'd2) < SIZE;
    assign ack_m    = sdr_ack == req_q;
    assign cur_hit  = cur_q.v && cur_q.t == widx;
    assign nxt_hit  = nxt_q.v && nxt_q.t == widx;
    assign need_pf  = nxt_in && !(nxt_q.v && nxt_q.t == widx_p1);
    assign go       = ioctl_upload && in_range;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= RESYNC;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESYNC:   state_d = cnt_q == CLAST ? IDLE : RESYNC;
            IDLE:     if (go) state_d = cur_hit ? (need_pf ? PREFETCH : IDLE) : nxt_hit ? PREFETCH : WAIT_CUR;
            PREFETCH: state_d = (go && cur_hit && need_pf) ? WAIT_NXT : IDLE;
            WAIT_CUR: state_d = ack_m ? IDLE : WAIT_CUR;
            WAIT_NXT: state_d = ack_m ? IDLE : WAIT_NXT;
            default:  state_d = RESYNC;
        endcase
    end

    // Datapath next-state: buffers, request toggle and fetch tag.
    always_comb begin
        cnt_d = cnt_q;
        req_d = req_q;
        tag_d = tag_q;
        cur_d = cur_q;
        nxt_d = nxt_q;
        case (state_q)
            RESYNC: begin
                cnt_d = cnt_q + 1'b1;
                req_d = cnt_q == CLAST ? sdr_ack : req_q;
            end
            IDLE: if (go && !cur_hit) begin
                nxt_d.v = 1'b0;
                cur_d   = nxt_hit ? nxt_q : '0;
                req_d   = nxt_hit ? req_q : ~req_q;
                tag_d   = nxt_hit ? tag_q : widx;
            end
            PREFETCH: if (go && cur_hit && need_pf) begin
                req_d = ~req_q;
                tag_d = widx_p1;
            end
            WAIT_CUR: if (ack_m) cur_d = '{v: 1'b1, t: tag_q, w: sdr_dout};
            WAIT_NXT: if (ack_m) nxt_d = '{v: 1'b1, t: tag_q, w: sdr_dout};
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            req_q <= 1'b0;
            tag_q <= '0;
            cur_q <= '0;
            nxt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            req_q <= req_d;
            tag_q <= tag_d;
            cur_q <= cur_d;
            nxt_q <= nxt_d;
        end
    end

    always_comb begin
        ioctl_din = (in_range && cur_hit) ? (ioctl_addr[0] ? cur_q.w[15:8] : cur_q.w[7:0]) : 8'hFF;
        busy      = state_q == WAIT_CUR && in_range;
        sdr_req   = req_q;
        sdr_addr  = BASE_ADDR + {tag_q, 1'b0};
    end
endmodule
